// File: rtl/key_schedule.sv
// Iterative AES-128 key expansion producing round keys 0..10 for the aes pipeline.
// Optional KEY_SCHEDULE_ZEROIZE_EN adds a synchronous zeroize_i key-clear input.
module key_schedule #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
`ifdef KEY_SCHEDULE_ZEROIZE_EN
    input  logic         zeroize_i,
`endif
    input  logic         key_valid_i,
    input  logic [127:0] key_i,
    output logic         busy_o,
    output logic         ready_o,
    output logic [127:0] round_key_o [11]
);

    localparam int R = ROUNDS_PER_CYCLE;

    if (!(R == 1 || R == 2 || R == 5 || R == 10)) begin : g_bad_r
        $error("key_schedule: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t       state, state_nx;
    logic [3:0]   cnt;
    logic [7:0]   rcon, rcon_nx, rc;
    logic [127:0] rk [11];
    logic [127:0] nk [R];
    logic [127:0] prev;
    logic         last;
    logic         zero;

`ifdef KEY_SCHEDULE_ZEROIZE_EN
    assign zero = zeroize_i;
`else
    assign zero = 1'b0;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as a^254 by square-and-multiply, then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] e;
        e = a;
        for (int i = 0; i < 6; i++) e = gmul(gmul(e, e), a);
        e = gmul(e, e);
        return e ^ {e[6:0], e[7]} ^ {e[5:0], e[7:6]}
                 ^ {e[4:0], e[7:5]} ^ {e[3:0], e[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] p,
                                              input logic [7:0] c);
        logic [31:0] t, w0, w1, w2, w3;
        t  = sub_word({p[23:0], p[31:24]}) ^ {c, 24'h0};
        w0 = p[127:96] ^ t;
        w1 = p[95:64] ^ w0;
        w2 = p[63:32] ^ w1;
        w3 = p[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    always_comb begin
        prev = rk[0];
        for (int j = 1; j < 11; j++)
            if (j == int'(cnt) - 1) prev = rk[j];
        rc = rcon;
        for (int i = 0; i < R; i++) begin
            nk[i] = next_key(prev, rc);
            prev  = nk[i];
            rc    = xtime(rc);
        end
        rcon_nx = rc;
    end

    always_comb begin
        last     = (int'(cnt) == 11 - R);
        state_nx = state;
        unique case (state)
            IDLE, DONE: if (key_valid_i) state_nx = EXPAND;
            EXPAND:     if (last) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            rcon  <= 8'h01;
            for (int j = 0; j < 11; j++) rk[j] <= '0;
        end else if (zero) begin
            state <= IDLE;
            cnt   <= '0;
            rcon  <= 8'h01;
            for (int j = 0; j < 11; j++) rk[j] <= '0;
        end else begin
            state <= state_nx;
            if (state != EXPAND) begin
                if (key_valid_i) begin
                    rk[0] <= key_i;
                    cnt   <= 4'd1;
                    rcon  <= 8'h01;
                end
            end else begin
                for (int i = 0; i < R; i++)
                    for (int j = 1; j < 11; j++)
                        if (int'(cnt) + i == j) rk[j] <= nk[i];
                cnt  <= cnt + 4'(R);
                rcon <= rcon_nx;
            end
        end
    end

    assign busy_o      = (state == EXPAND);
    assign ready_o     = (state == DONE);
    assign round_key_o = rk;

endmodule

// File: tb/tb_key_schedule.sv
// Randomized bench for key_schedule: four instances (R = 1, 2, 5, 10) share
// stimulus and are compared against a FIPS-197 word-array reference schedule.
module tb_key_schedule;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0;
    logic [127:0] key_in = '0;
    logic         zeroize = 1'b0;
    logic [3:0]   busy, ready;
    logic [127:0] rk_all [4][11];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int RPC = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
        logic [127:0] keys [11];
        key_schedule #(.ROUNDS_PER_CYCLE(RPC)) u_dut (
            .clk(clk),
            .rst(rst),
`ifdef KEY_SCHEDULE_ZEROIZE_EN
            .zeroize_i(zeroize),
`endif
            .key_valid_i(key_valid),
            .key_i(key_in),
            .busy_o(busy[g]),
            .ready_o(ready[g]),
            .round_key_o(keys)
        );
        for (genvar j = 0; j < 11; j++) begin : g_k
            assign rk_all[g][j] = keys[j];
        end
    end

    // reference model
    logic [7:0]   sb [256];
    bit           mb [4];
    bit           mr [4];
    int           rem [4];
    logic [127:0] ek [4][11];

    function automatic int rpc(int d);
        return (d == 0) ? 1 : (d == 1) ? 2 : (d == 2) ? 5 : 10;
    endfunction

    // S-box built by walking the multiplicative group with generator 3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
                  ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    task automatic schedule(input logic [127:0] k, output logic [127:0] out [11]);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]}
                    ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            out[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic model_clear();
        for (int d = 0; d < 4; d++) begin
            mb[d]  = 1'b0;
            mr[d]  = 1'b0;
            rem[d] = 0;
            for (int j = 0; j < 11; j++) ek[d][j] = '0;
        end
    endtask

    task automatic model_edge(input bit kv, input logic [127:0] k, input bit z);
        logic [127:0] s [11];
        schedule(k, s);
        if (z) begin
            model_clear();
            return;
        end
        for (int d = 0; d < 4; d++) begin
            if (!mb[d]) begin
                if (kv) begin
                    for (int j = 0; j < 11; j++) ek[d][j] = s[j];
                    rem[d] = 10 / rpc(d);
                    mb[d]  = 1'b1;
                    mr[d]  = 1'b0;
                end
            end else begin
                rem[d]--;
                if (rem[d] == 0) begin
                    mb[d] = 1'b0;
                    mr[d] = 1'b1;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 4; d++) begin
            check($sformatf("busy r%0d", rpc(d)), 128'(busy[d]), 128'(mb[d]));
            check($sformatf("ready r%0d", rpc(d)), 128'(ready[d]), 128'(mr[d]));
            if (!mb[d])
                for (int j = 0; j < 11; j++)
                    check($sformatf("rk r%0d[%0d]", rpc(d), j),
                          rk_all[d][j], ek[d][j]);
        end
    endtask

    task automatic step(input bit kv, input logic [127:0] k, input bit z = 1'b0);
        key_valid = kv;
        key_in    = k;
        zeroize   = z;
        @(posedge clk);
        model_edge(kv, k, z);
        @(negedge clk);
        key_valid = 1'b0;
        zeroize   = 1'b0;
        compare_all();
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        logic [127:0] ka;
        build_sbox();
        model_clear();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b0;
        @(negedge clk);

        step(1'b1, FIPS_KEY);
        repeat (11) step(1'b0, '0);
        check("fips rk1", rk_all[0][1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("fips rk10", rk_all[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // back-to-back rekey with the zero key
        step(1'b1, '0);
        repeat (11) step(1'b0, '0);
        check("zero r2 rk1", rk_all[1][1], 128'h62636363626363636263636362636363);
        check("zero r2 rk10", rk_all[1][10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        check("zero r5 rk10", rk_all[2][10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // pulses during EXPAND must be ignored
        ka = rand_key();
        step(1'b1, ka);
        repeat (3) step(1'b1, rand_key());
        repeat (8) step(1'b0, '0);

        // asynchronous reset mid-expansion
        step(1'b1, rand_key());
        repeat (3) step(1'b0, '0);
        #2 rst = 1'b1;
        #1 model_clear();
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, rand_key());
        repeat (11) step(1'b0, '0);

        // random traffic
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 3) == 0, rand_key());
        repeat (11) step(1'b0, '0);

`ifdef KEY_SCHEDULE_ZEROIZE_EN
        step(1'b1, rand_key());
        repeat (11) step(1'b0, '0);
        step(1'b0, '0, 1'b1);
        step(1'b1, rand_key());
        step(1'b1, rand_key(), 1'b1);
        repeat (3) step(1'b0, '0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
